// File: rtl/opfetch_stage.sv
// Operand-fetch stage: resolves rs1/rs2 from RF / EX / WB, stalls on load-use,
// one-entry output register. Optional macro OPF_WB_BYPASS_EN enables WB forwarding.
module opfetch_stage (
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    input  logic        s_flush_i,
    input  logic        s_id_valid_i,
    output logic        s_id_ready_o,
    input  logic [4:0]  s_id_rs1_i,
    input  logic [4:0]  s_id_rs2_i,
    input  logic [4:0]  s_id_rd_i,
    input  logic        s_id_we_i,
    output logic [4:0]  s_r_p1_add_o,
    output logic [4:0]  s_r_p2_add_o,
    input  logic [31:0] s_p1_val_i,
    input  logic [31:0] s_p2_val_i,
    input  logic        s_ex_we_i,
    input  logic        s_ex_ld_i,
    input  logic [4:0]  s_ex_add_i,
    input  logic [31:0] s_ex_val_i,
    input  logic        s_mawb_we_i,
    input  logic [4:0]  s_mawb_add_i,
    input  logic [31:0] s_mawb_val_i,
    output logic        s_op_valid_o,
    input  logic        s_op_ready_i,
    output logic [31:0] s_op_rs1_val_o,
    output logic [31:0] s_op_rs2_val_o,
    output logic [4:0]  s_op_rd_o,
    output logic        s_op_we_o,
    output logic [15:0] s_stall_cnt_o
);

    logic        rs1_nz, rs2_nz;
    logic        ex_fwd1, ex_fwd2;
    logic        ld_haz1, ld_haz2;
    logic        wb_hit1, wb_hit2;
    logic        hazard, accept, drain;
    logic [31:0] rs1_res, rs2_res;

    logic        op_valid_q, op_valid_d;
    logic [31:0] rs1_val_q, rs1_val_d;
    logic [31:0] rs2_val_q, rs2_val_d;
    logic [4:0]  rd_q, rd_d;
    logic        we_q, we_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign s_r_p1_add_o = s_id_rs1_i;
    assign s_r_p2_add_o = s_id_rs2_i;

    assign rs1_nz  = (s_id_rs1_i != 5'd0);
    assign rs2_nz  = (s_id_rs2_i != 5'd0);
    assign ex_fwd1 = s_ex_we_i && !s_ex_ld_i && (s_ex_add_i == s_id_rs1_i);
    assign ex_fwd2 = s_ex_we_i && !s_ex_ld_i && (s_ex_add_i == s_id_rs2_i);
    assign ld_haz1 = rs1_nz && s_ex_we_i && s_ex_ld_i && (s_ex_add_i == s_id_rs1_i);
    assign ld_haz2 = rs2_nz && s_ex_we_i && s_ex_ld_i && (s_ex_add_i == s_id_rs2_i);
    assign wb_hit1 = s_mawb_we_i && (s_mawb_add_i == s_id_rs1_i);
    assign wb_hit2 = s_mawb_we_i && (s_mawb_add_i == s_id_rs2_i);

`ifdef OPF_WB_BYPASS_EN
    assign hazard = s_id_valid_i && (ld_haz1 || ld_haz2);
`else
    // Without the WB bypass, wait one cycle for the write to reach the RF
    // (only when EX is not already supplying that operand).
    logic wb_val_unused;
    assign wb_val_unused = ^s_mawb_val_i;
    assign hazard = s_id_valid_i && (ld_haz1 || ld_haz2 ||
                    (rs1_nz && wb_hit1 && !ex_fwd1) ||
                    (rs2_nz && wb_hit2 && !ex_fwd2));
`endif

    assign s_id_ready_o = !hazard && (!op_valid_q || s_op_ready_i) && !s_flush_i;
    assign accept       = s_id_valid_i && s_id_ready_o;
    assign drain        = op_valid_q && s_op_ready_i;

    always_comb begin
        rs1_res = s_p1_val_i;
        if (!rs1_nz)
            rs1_res = 32'd0;
        else if (ex_fwd1)
            rs1_res = s_ex_val_i;
`ifdef OPF_WB_BYPASS_EN
        else if (wb_hit1)
            rs1_res = s_mawb_val_i;
`endif
    end

    always_comb begin
        rs2_res = s_p2_val_i;
        if (!rs2_nz)
            rs2_res = 32'd0;
        else if (ex_fwd2)
            rs2_res = s_ex_val_i;
`ifdef OPF_WB_BYPASS_EN
        else if (wb_hit2)
            rs2_res = s_mawb_val_i;
`endif
    end

    always_comb begin
        op_valid_d = op_valid_q;
        rs1_val_d  = rs1_val_q;
        rs2_val_d  = rs2_val_q;
        rd_d       = rd_q;
        we_d       = we_q;
        // Flush wins; accept during drain replaces the entry without a bubble.
        if (s_flush_i)
            op_valid_d = 1'b0;
        else if (accept)
            op_valid_d = 1'b1;
        else if (drain)
            op_valid_d = 1'b0;
        if (accept) begin
            rs1_val_d = rs1_res;
            rs2_val_d = rs2_res;
            rd_d      = s_id_rd_i;
            we_d      = s_id_we_i;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            op_valid_q  <= 1'b0;
            rs1_val_q   <= 32'd0;
            rs2_val_q   <= 32'd0;
            rd_q        <= 5'd0;
            we_q        <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            op_valid_q  <= op_valid_d;
            rs1_val_q   <= rs1_val_d;
            rs2_val_q   <= rs2_val_d;
            rd_q        <= rd_d;
            we_q        <= we_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign s_op_valid_o   = op_valid_q;
    assign s_op_rs1_val_o = rs1_val_q;
    assign s_op_rs2_val_o = rs2_val_q;
    assign s_op_rd_o      = rd_q;
    assign s_op_we_o      = we_q;
    assign s_stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_opfetch_stage.sv
// Scoreboard bench for opfetch_stage: expected operands queued at accept,
// compared when EX takes the entry. Follows OPF_WB_BYPASS_EN if defined.
module tb_opfetch_stage;

    logic        s_clk_i = 1'b0;
    logic        s_reset_i;
    logic        s_flush_i;
    logic        s_id_valid_i;
    logic        s_id_ready_o;
    logic [4:0]  s_id_rs1_i, s_id_rs2_i, s_id_rd_i;
    logic        s_id_we_i;
    logic [4:0]  s_r_p1_add_o, s_r_p2_add_o;
    logic [31:0] s_p1_val_i, s_p2_val_i;
    logic        s_ex_we_i, s_ex_ld_i;
    logic [4:0]  s_ex_add_i;
    logic [31:0] s_ex_val_i;
    logic        s_mawb_we_i;
    logic [4:0]  s_mawb_add_i;
    logic [31:0] s_mawb_val_i;
    logic        s_op_valid_o;
    logic        s_op_ready_i;
    logic [31:0] s_op_rs1_val_o, s_op_rs2_val_o;
    logic [4:0]  s_op_rd_o;
    logic        s_op_we_o;
    logic [15:0] s_stall_cnt_o;

    logic [31:0] rf [32];
    logic [69:0] sb_q [$];
    logic [69:0] dropped;
    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_stall = 0;

    always #5 s_clk_i = ~s_clk_i;

    assign s_p1_val_i = rf[s_r_p1_add_o];
    assign s_p2_val_i = rf[s_r_p2_add_o];

    opfetch_stage dut (
        .s_clk_i        (s_clk_i),
        .s_reset_i      (s_reset_i),
        .s_flush_i      (s_flush_i),
        .s_id_valid_i   (s_id_valid_i),
        .s_id_ready_o   (s_id_ready_o),
        .s_id_rs1_i     (s_id_rs1_i),
        .s_id_rs2_i     (s_id_rs2_i),
        .s_id_rd_i      (s_id_rd_i),
        .s_id_we_i      (s_id_we_i),
        .s_r_p1_add_o   (s_r_p1_add_o),
        .s_r_p2_add_o   (s_r_p2_add_o),
        .s_p1_val_i     (s_p1_val_i),
        .s_p2_val_i     (s_p2_val_i),
        .s_ex_we_i      (s_ex_we_i),
        .s_ex_ld_i      (s_ex_ld_i),
        .s_ex_add_i     (s_ex_add_i),
        .s_ex_val_i     (s_ex_val_i),
        .s_mawb_we_i    (s_mawb_we_i),
        .s_mawb_add_i   (s_mawb_add_i),
        .s_mawb_val_i   (s_mawb_val_i),
        .s_op_valid_o   (s_op_valid_o),
        .s_op_ready_i   (s_op_ready_i),
        .s_op_rs1_val_o (s_op_rs1_val_o),
        .s_op_rs2_val_o (s_op_rs2_val_o),
        .s_op_rd_o      (s_op_rd_o),
        .s_op_we_o      (s_op_we_o),
        .s_stall_cnt_o  (s_stall_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge s_clk_i);
        #1;
    endtask

    // Present an instruction until accepted (bounded); queue its expected entry.
    task automatic send(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic we, input logic [31:0] e1, input logic [31:0] e2);
        logic ok;
        ok = 1'b0;
        s_id_rs1_i   = rs1;
        s_id_rs2_i   = rs2;
        s_id_rd_i    = rd;
        s_id_we_i    = we;
        s_id_valid_i = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (s_id_ready_o) begin
                sb_q.push_back({e1, e2, rd, we});
                ok = 1'b1;
            end
            step();
        end
        s_id_valid_i = 1'b0;
        chk("accept", 64'(ok), 64'd1);
    endtask

    always @(negedge s_clk_i) begin : mon_blk
        logic [69:0] e;
        if (!s_reset_i && s_op_valid_o && s_op_ready_i) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_rs1", 64'(s_op_rs1_val_o), 64'(e[69:38]));
                chk("sb_rs2", 64'(s_op_rs2_val_o), 64'(e[37:6]));
                chk("sb_rd_we", 64'({s_op_rd_o, s_op_we_o}), 64'(e[5:0]));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'hC0DE_0000 | i;
        rf[3] = 32'd0;
        rf[7] = 32'h7777_7777;
        s_reset_i = 1'b1; s_flush_i = 1'b0; s_id_valid_i = 1'b0;
        s_id_rs1_i = '0; s_id_rs2_i = '0; s_id_rd_i = '0; s_id_we_i = 1'b0;
        s_ex_we_i = 1'b0; s_ex_ld_i = 1'b0; s_ex_add_i = '0; s_ex_val_i = '0;
        s_mawb_we_i = 1'b0; s_mawb_add_i = '0; s_mawb_val_i = '0;
        s_op_ready_i = 1'b1;

        repeat (3) step();
        chk("rst_valid", 64'(s_op_valid_o), 64'd0);
        chk("rst_rs1", 64'(s_op_rs1_val_o), 64'd0);
        chk("rst_rs2", 64'(s_op_rs2_val_o), 64'd0);
        chk("rst_rd_we", 64'({s_op_rd_o, s_op_we_o}), 64'd0);
        chk("rst_stall", 64'(s_stall_cnt_o), 64'd0);
        s_reset_i = 1'b0;
        step();
        chk("rst_ready", 64'(s_id_ready_o), 64'd1);

        // EX forward of a non-load result
        s_ex_we_i = 1'b1; s_ex_add_i = 5'd3; s_ex_val_i = 32'h1234; s_ex_ld_i = 1'b0;
        send(5'd3, 5'd1, 5'd10, 1'b1, 32'h1234, rf[1]);
        s_ex_we_i = 1'b0;
        chk("lat1_valid", 64'(s_op_valid_o), 64'd1);
        chk("ex_fwd", 64'(s_op_rs1_val_o), 64'h1234);
        chk("rf_addr", 64'({s_r_p1_add_o, s_r_p2_add_o}), 64'({5'd3, 5'd1}));
        step();
        chk("drain_clear", 64'(s_op_valid_o), 64'd0);

        // x0 always reads zero
        s_ex_we_i = 1'b1; s_ex_add_i = 5'd0; s_ex_val_i = 32'hFFFF_FFFF;
        s_mawb_we_i = 1'b1; s_mawb_add_i = 5'd0; s_mawb_val_i = 32'hFFFF_FFFF;
        send(5'd0, 5'd0, 5'd1, 1'b0, 32'd0, 32'd0);
        chk("x0_zero", 64'(s_op_rs1_val_o), 64'd0);
        s_ex_we_i = 1'b0; s_mawb_we_i = 1'b0;
        step();

        // back-to-back accept with drain: no bubble
        send(5'd2, 5'd4, 5'd11, 1'b0, rf[2], rf[4]);
        send(5'd6, 5'd8, 5'd12, 1'b1, rf[6], rf[8]);
        chk("no_bubble", 64'(s_op_valid_o), 64'd1);
        chk("replace_rd", 64'(s_op_rd_o), 64'd12);
        step();

`ifdef OPF_WB_BYPASS_EN
        // EX has priority over WB on the same register
        s_ex_we_i = 1'b1; s_ex_add_i = 5'd9; s_ex_val_i = 32'hEEEE_0000; s_ex_ld_i = 1'b0;
        s_mawb_we_i = 1'b1; s_mawb_add_i = 5'd9; s_mawb_val_i = 32'hBBBB_0000;
        send(5'd9, 5'd9, 5'd13, 1'b1, 32'hEEEE_0000, 32'hEEEE_0000);
        s_ex_we_i = 1'b0; s_mawb_we_i = 1'b0;
        step();
`endif

        // load-use hazard on rs2
        s_ex_we_i = 1'b1; s_ex_ld_i = 1'b1; s_ex_add_i = 5'd5;
        s_id_rs1_i = 5'd1; s_id_rs2_i = 5'd5; s_id_rd_i = 5'd14; s_id_we_i = 1'b1;
        s_id_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ld_haz_ready", 64'(s_id_ready_o), 64'd0);
            step();
            exp_stall++;
            chk("stall_inc", 64'(s_stall_cnt_o), 64'(exp_stall));
        end
        s_ex_ld_i = 1'b0; s_ex_we_i = 1'b0;
        send(5'd1, 5'd5, 5'd14, 1'b1, rf[1], rf[5]);
        chk("stall_hold", 64'(s_stall_cnt_o), 64'(exp_stall));
        step();

        // WB match on rs1 with stale RF
        s_mawb_we_i = 1'b1; s_mawb_add_i = 5'd7; s_mawb_val_i = 32'hA5A5_A5A5;
`ifndef OPF_WB_BYPASS_EN
        s_id_rs1_i = 5'd7; s_id_rs2_i = 5'd0; s_id_rd_i = 5'd15; s_id_we_i = 1'b1;
        s_id_valid_i = 1'b1;
        #1;
        chk("wb_haz_ready", 64'(s_id_ready_o), 64'd0);
        step();
        exp_stall++;
        rf[7] = 32'hA5A5_A5A5;
        s_mawb_we_i = 1'b0;
`endif
        send(5'd7, 5'd0, 5'd15, 1'b1, 32'hA5A5_A5A5, 32'd0);
        s_mawb_we_i = 1'b0;
        chk("wb_val", 64'(s_op_rs1_val_o), 64'hA5A5_A5A5);
        chk("wb_stall", 64'(s_stall_cnt_o), 64'(exp_stall));
        step();

        // backpressure hold then flush
        s_op_ready_i = 1'b0;
        send(5'd2, 5'd10, 5'd17, 1'b1, rf[2], rf[10]);
        s_id_rs1_i = 5'd4; s_id_rs2_i = 5'd6; s_id_rd_i = 5'd20; s_id_we_i = 1'b0;
        s_id_valid_i = 1'b1;
        #1;
        chk("bp_ready", 64'(s_id_ready_o), 64'd0);
        chk("hold_rs1", 64'(s_op_rs1_val_o), 64'(rf[2]));
        chk("hold_rd", 64'(s_op_rd_o), 64'd17);
        step();
        chk("hold_rs2", 64'(s_op_rs2_val_o), 64'(rf[10]));
        chk("hold_valid", 64'(s_op_valid_o), 64'd1);
        s_flush_i = 1'b1;
        #1;
        chk("flush_ready", 64'(s_id_ready_o), 64'd0);
        step();
        s_flush_i = 1'b0;
        dropped = sb_q.pop_front();
        chk("flush_clear", 64'(s_op_valid_o), 64'd0);
        send(5'd4, 5'd6, 5'd20, 1'b0, rf[4], rf[6]);
        step();
        chk("bp_still_valid", 64'(s_op_valid_o), 64'd1);
        s_op_ready_i = 1'b1;
        step();
        chk("bp_drained", 64'(s_op_valid_o), 64'd0);

        // reset while stalled with a held entry
        s_op_ready_i = 1'b0;
        send(5'd1, 5'd2, 5'd21, 1'b1, rf[1], rf[2]);
        s_ex_we_i = 1'b1; s_ex_ld_i = 1'b1; s_ex_add_i = 5'd5;
        s_id_rs1_i = 5'd0; s_id_rs2_i = 5'd5; s_id_valid_i = 1'b1;
        step();
        exp_stall++;
        chk("mid_stall_cnt", 64'(s_stall_cnt_o), 64'(exp_stall));
        s_reset_i = 1'b1;
        step();
        chk("mid_rst_valid", 64'(s_op_valid_o), 64'd0);
        chk("mid_rst_stall", 64'(s_stall_cnt_o), 64'd0);
        sb_q.delete();
        exp_stall = 0;
        s_ex_we_i = 1'b0; s_ex_ld_i = 1'b0; s_id_valid_i = 1'b0;
        s_reset_i = 1'b0; s_op_ready_i = 1'b1;
        step();
        chk("post_rst_ready", 64'(s_id_ready_o), 64'd1);

        // saturation
        s_ex_we_i = 1'b1; s_ex_ld_i = 1'b1; s_ex_add_i = 5'd5;
        s_id_rs2_i = 5'd5; s_id_valid_i = 1'b1;
        repeat (70000) @(posedge s_clk_i);
        #1;
        chk("stall_sat", 64'(s_stall_cnt_o), 64'hFFFF);
        step();
        chk("stall_nowrap", 64'(s_stall_cnt_o), 64'hFFFF);
        s_reset_i = 1'b1;
        step();
        chk("sat_rst", 64'(s_stall_cnt_o), 64'd0);
        s_reset_i = 1'b0; s_ex_we_i = 1'b0; s_ex_ld_i = 1'b0; s_id_valid_i = 1'b0;
        step();

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
